// File: rtl/instrumented_adder_meas.sv
// Ring-oscillator delay measurement around an instrumented adder: settle, count ring edges over a window, report.
// Optional INSTR_ADDER_SUM_CAPTURE_EN adds sum_in/sum_q to snapshot the adder sum at the end of settling.
module instrumented_adder_meas #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned WIN_W      = 16,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n,
    input  logic                     start,
    input  logic [WIDTH-1:0]         a_in,
    input  logic [WIDTH-1:0]         b_in,
    input  logic [$clog2(WIDTH)-1:0] tap_sel_in,
    input  logic [WIN_W-1:0]         window,
    input  logic                     ring_osc,
    input  logic                     result_ack,
`ifdef INSTR_ADDER_SUM_CAPTURE_EN
    input  logic [WIDTH-1:0]         sum_in,
    output logic [WIDTH-1:0]         sum_q,
`endif
    output logic [WIDTH-1:0]         a_op,
    output logic [WIDTH-1:0]         b_op,
    output logic [$clog2(WIDTH)-1:0] tap_sel,
    output logic                     ring_en,
    output logic                     busy,
    output logic [CNT_W-1:0]         result,
    output logic                     result_valid,
    output logic                     overflow
);

    localparam int unsigned TAP_W = $clog2(WIDTH);
    localparam int unsigned SC_W  = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);
    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_op_q, a_op_d, b_op_q, b_op_d;
    logic [TAP_W-1:0]   tap_sel_q, tap_sel_d;
    logic [WIN_W-1:0]   window_q, window_d, win_cnt_q, win_cnt_d;
    logic [SC_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d, edge_next;
    logic               run_ovf_q, run_ovf_d, ovf_next;
    logic [CNT_W-1:0]   result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic               overflow_q, overflow_d;
    logic               ring_en_q, ring_en_d;
    logic               busy_q, busy_d;
    logic [2:0]         sync_q, sync_d;
    logic               rise;
`ifdef INSTR_ADDER_SUM_CAPTURE_EN
    logic [WIDTH-1:0]   sum_cap_q, sum_cap_d;
`endif

    always_comb begin
        // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the edge-detect history
        sync_d = {sync_q[1:0], ring_osc};
        rise   = sync_q[1] & ~sync_q[2];

        edge_next = edge_cnt_q;
        ovf_next  = run_ovf_q;
        if (rise && state_q == COUNT) begin
            if (edge_cnt_q == '1) begin
                ovf_next = 1'b1;
            end else begin
                edge_next = edge_cnt_q + CNT_W'(1);
            end
        end

        state_d        = state_q;
        a_op_d         = a_op_q;
        b_op_d         = b_op_q;
        tap_sel_d      = tap_sel_q;
        window_d       = window_q;
        win_cnt_d      = win_cnt_q;
        settle_cnt_d   = settle_cnt_q;
        edge_cnt_d     = edge_cnt_q;
        run_ovf_d      = run_ovf_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        overflow_d     = overflow_q;
        ring_en_d      = ring_en_q;
        busy_d         = busy_q;
`ifdef INSTR_ADDER_SUM_CAPTURE_EN
        sum_cap_d      = sum_cap_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = SETTLE;
                    a_op_d       = a_in;
                    b_op_d       = b_in;
                    tap_sel_d    = tap_sel_in;
                    window_d     = window;
                    settle_cnt_d = '0;
                    ring_en_d    = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            SETTLE: begin
                settle_cnt_d = settle_cnt_q + SC_W'(1);
                if (settle_cnt_q == SETTLE_LAST) begin
                    edge_cnt_d = '0;
                    run_ovf_d  = 1'b0;
                    win_cnt_d  = '0;
`ifdef INSTR_ADDER_SUM_CAPTURE_EN
                    sum_cap_d  = sum_in;
`endif
                    if (window_q == '0) begin
                        state_d        = DONE;
                        result_d       = '0;
                        overflow_d     = 1'b0;
                        result_valid_d = 1'b1;
                        ring_en_d      = 1'b0;
                    end else begin
                        state_d = COUNT;
                    end
                end
            end
            COUNT: begin
                win_cnt_d  = win_cnt_q + WIN_W'(1);
                edge_cnt_d = edge_next;
                run_ovf_d  = ovf_next;
                // The final COUNT cycle's edge is folded into the latched result
                if (win_cnt_q == window_q - WIN_W'(1)) begin
                    state_d        = DONE;
                    result_d       = edge_next;
                    overflow_d     = ovf_next;
                    result_valid_d = 1'b1;
                    ring_en_d      = 1'b0;
                end
            end
            DONE: begin
                if (result_ack) begin
                    state_d        = IDLE;
                    result_valid_d = 1'b0;
                    busy_d         = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q        <= IDLE;
            a_op_q         <= '0;
            b_op_q         <= '0;
            tap_sel_q      <= '0;
            window_q       <= '0;
            win_cnt_q      <= '0;
            settle_cnt_q   <= '0;
            edge_cnt_q     <= '0;
            run_ovf_q      <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            ring_en_q      <= 1'b0;
            busy_q         <= 1'b0;
            sync_q         <= '0;
`ifdef INSTR_ADDER_SUM_CAPTURE_EN
            sum_cap_q      <= '0;
`endif
        end else begin
            state_q        <= state_d;
            a_op_q         <= a_op_d;
            b_op_q         <= b_op_d;
            tap_sel_q      <= tap_sel_d;
            window_q       <= window_d;
            win_cnt_q      <= win_cnt_d;
            settle_cnt_q   <= settle_cnt_d;
            edge_cnt_q     <= edge_cnt_d;
            run_ovf_q      <= run_ovf_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            overflow_q     <= overflow_d;
            ring_en_q      <= ring_en_d;
            busy_q         <= busy_d;
            sync_q         <= sync_d;
`ifdef INSTR_ADDER_SUM_CAPTURE_EN
            sum_cap_q      <= sum_cap_d;
`endif
        end
    end

    assign a_op         = a_op_q;
    assign b_op         = b_op_q;
    assign tap_sel      = tap_sel_q;
    assign ring_en      = ring_en_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign overflow     = overflow_q;
`ifdef INSTR_ADDER_SUM_CAPTURE_EN
    assign sum_q        = sum_cap_q;
`endif

endmodule

// File: doc/instrumented_adder_meas.md
INSTRUMENTED_ADDER_MEAS -- requirements
Module: instrumented_adder_meas

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: adder operand width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 24: ring-edge counter width.
REQ-003 The block SHALL have parameter WIN_W, default 16: measurement-window length register width.
REQ-004 The block SHALL have parameter SETTLE_CYC, default 4: ring settle cycles before counting, minimum 1.
REQ-005 The block SHALL have one clock and reset: asynchronous, active-low.
REQ-006 wb_clk_i  in  1  sole clock.
REQ-007 wb_rst_n  in  1  asynchronous active-low reset.
REQ-008 start  in  1  one-cycle request to begin a measurement.
REQ-009 a_in, b_in  in  WIDTH each  operands, sampled on the accepted start.
REQ-010 tap_sel_in  in  $clog2(WIDTH)  sum bit closing the ring, sampled on the accepted start.
REQ-011 window  in  WIN_W  count-window length in clocks, sampled on the accepted start.
REQ-012 ring_osc  in  1  asynchronous ring-oscillator output from the adder chain.
REQ-013 result_ack  in  1  consumer acknowledge of result.
REQ-014 a_op, b_op  out  WIDTH each  registered operands driven to the adder.
REQ-015 tap_sel  out  $clog2(WIDTH)  registered tap select driven to the adder.
REQ-016 ring_en  out  1  enables the ring oscillator.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 result  out  CNT_W  ring rising-edge count.
REQ-019 result_valid  out  1  result available.
REQ-020 overflow  out  1  counter saturated during the last measurement.

Function
REQ-021 The FSM SHALL have states IDLE, SETTLE, COUNT and DONE.
REQ-022 In IDLE, start=1 SHALL capture operands, tap_sel and window, and move to SETTLE on the next edge; start SHALL be ignored in any other state.
REQ-023 ring_en SHALL be 1 exactly while in SETTLE or COUNT.
REQ-024 SETTLE SHALL last exactly SETTLE_CYC cycles, then move to COUNT with the edge counter cleared.
REQ-025 COUNT SHALL last exactly the captured window cycles, then move to DONE; with window=0 SETTLE SHALL move directly to DONE, giving result=0.
REQ-026 ring_osc SHALL pass through a 2-flop synchronizer plus a third edge-detect flop; a rising edge SHALL be counted only when it is detected in a COUNT cycle.
REQ-027 The counter SHALL saturate at 2^CNT_W-1 and set overflow; it SHALL never wrap.
REQ-028 On entry to DONE, result and overflow SHALL be latched and result_valid SHALL assert in the same cycle DONE is entered.
REQ-029 result_valid SHALL stay high until result_ack=1 is sampled in DONE; the FSM SHALL then return to IDLE with result_valid=0 on the next cycle.
REQ-030 result and overflow SHALL hold their values until the next DONE entry.
REQ-031 result_ack outside DONE SHALL be ignored.
REQ-032 start and result_ack both high in DONE SHALL complete the ack only; the start is dropped.

Reset
REQ-033 Asserting wb_rst_n=0 SHALL immediately force IDLE and clear all outputs and internal state to 0, including mid-measurement.
REQ-034 After reset is released, the first start SHALL be acceptable on the first clock edge.

Configuration
REQ-035 When INSTR_ADDER_SUM_CAPTURE_EN is defined, the block SHALL add input sum_in (WIDTH) and output sum_q (WIDTH); sum_q SHALL latch sum_in on the last SETTLE cycle and reset to 0.
REQ-036 When INSTR_ADDER_SUM_CAPTURE_EN is undefined, sum_in and sum_q SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-037 Setup: ring_osc toggling every 2 clocks, window=10, SETTLE_CYC=4. Expected: start -> ring_en high 14 cycles, result=2 or 3, result_valid held until ack, busy low the cycle after ack.
REQ-038 Setup: window=0. Expected: start -> DONE after 4 SETTLE cycles, result=0, overflow=0.
REQ-039 Setup: CNT_W=4, ring_osc toggling every clock, window=100. Expected: result=15, overflow=1.
REQ-040 Setup: start pulsed in SETTLE, COUNT and DONE. Expected: no restart, and operands unchanged from the first capture.
REQ-041 Setup: wb_rst_n pulsed low mid-COUNT. Expected: busy=0, ring_en=0, result=0, result_valid=0 immediately; a fresh measurement then completes normally.
REQ-042 Setup: with INSTR_ADDER_SUM_CAPTURE_EN defined, a_in=5, b_in=7, sum_in driven to 12. Expected: sum_q=12 from COUNT onward.
